// File: rtl/energy_logger_pkg.sv
// Shared types and width helpers for the energy sample logger.
// Record layout is {ch, data}; the typedef is sized from the default parameters.
package energy_logger_pkg;

    localparam int DATA_W_DEF     = 8;
    localparam int NUM_CH_DEF     = 4;
    localparam int AVG_LOG2_DEF   = 2;
    localparam int FIFO_DEPTH_DEF = 8;

    function automatic int ch_width(input int num_ch);
        return (num_ch < 2) ? 1 : $clog2(num_ch);
    endfunction

    // Sum of 2^avg_log2 samples of data_w bits never exceeds data_w+avg_log2 bits
    function automatic int acc_width(input int data_w, input int avg_log2);
        return data_w + avg_log2;
    endfunction

    localparam int CH_W_DEF  = ch_width(NUM_CH_DEF);
    localparam int ACC_W_DEF = acc_width(DATA_W_DEF, AVG_LOG2_DEF);

    typedef struct packed {
        logic [CH_W_DEF-1:0]   ch;
        logic [DATA_W_DEF-1:0] data;
    } log_rec_t;

endpackage

// File: rtl/logger_fifo.sv
// Synchronous record FIFO with a registered read port.
// A write while full is accepted only when a pop happens on the same edge.
module logger_fifo #(
    parameter int W     = 12,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic         r_valid,
    output logic [W-1:0] r_data,
    output logic         empty,
    output logic         full,
    output logic         drop
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic          do_rd;
    logic          do_wr;

    assign do_rd      = rd_en && !empty;
    assign do_wr      = wr_en && (!full || do_rd);
    assign drop       = wr_en && full && !do_rd;
    assign count_next = count + (AW+1)'(do_wr) - (AW+1)'(do_rd);

    // Storage has no reset; occupancy is tracked by count and the pointers
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
            empty   <= 1'b1;
            full    <= 1'b0;
        end else begin
            r_valid <= do_rd;
            if (do_rd) begin
                r_data <= mem[rd_ptr];
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            count <= count_next;
            empty <= (count_next == '0);
            full  <= (count_next == (AW+1)'(DEPTH));
        end
    end

endmodule

// File: rtl/energy_sample_logger.sv
// Multi-channel windowed averaging logger feeding a record FIFO.
// Optional per-channel threshold alarm enabled by defining LOGGER_ALARM_EN.
module energy_sample_logger
    import energy_logger_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int NUM_CH     = NUM_CH_DEF,
    parameter int AVG_LOG2   = AVG_LOG2_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    localparam int CH_W      = ch_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              s_valid,
    input  logic [CH_W-1:0]   s_ch,
    input  logic [DATA_W-1:0] s_data,
    input  logic              rd_en,
    input  logic              clr_ovf,
    input  logic [DATA_W-1:0] alarm_thr,
    output logic              r_valid,
    output logic [DATA_W-1:0] r_data,
    output logic [CH_W-1:0]   r_ch,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic [NUM_CH-1:0] alarm
);

    localparam int ACC_W = acc_width(DATA_W, AVG_LOG2);
    // A zero-length counter is not legal, so AVG_LOG2=0 keeps one bit pinned at 0
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'((1 << AVG_LOG2) - 1);
    localparam int REC_W = CH_W + DATA_W;

    logic [ACC_W-1:0]  acc [NUM_CH];
    logic [CNT_W-1:0]  cnt [NUM_CH];

    logic              accept;
    logic              win_done;
    logic [ACC_W-1:0]  sum;
    logic [ACC_W-1:0]  sum_shift;
    logic [DATA_W-1:0] avg;
    logic              rec_wr;
    logic              rec_drop;
    logic [REC_W-1:0]  rec_in;
    logic [REC_W-1:0]  rec_out;

    assign accept    = ena && s_valid;
    assign win_done  = (cnt[s_ch] == WIN_LAST);
    assign sum       = acc[s_ch] + ACC_W'(s_data);
    assign sum_shift = sum >> AVG_LOG2;
    assign avg       = sum_shift[DATA_W-1:0];
    assign rec_wr    = accept && win_done;
    assign rec_in    = {s_ch, avg};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc[i] <= '0;
                cnt[i] <= '0;
            end
        end else if (accept) begin
            if (win_done) begin
                acc[s_ch] <= '0;
                cnt[s_ch] <= '0;
            end else begin
                acc[s_ch] <= sum;
                cnt[s_ch] <= cnt[s_ch] + CNT_W'(1);
            end
        end
    end

    logger_fifo #(
        .W     (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (rec_wr),
        .wr_data (rec_in),
        .rd_en   (rd_en),
        .r_valid (r_valid),
        .r_data  (rec_out),
        .empty   (empty),
        .full    (full),
        .drop    (rec_drop)
    );

    assign r_ch   = rec_out[REC_W-1:DATA_W];
    assign r_data = rec_out[DATA_W-1:0];

    // A drop coinciding with clr_ovf leaves the flag set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (rec_drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

`ifdef LOGGER_ALARM_EN
    // Updated on every completed window, whether the record was stored or dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm <= '0;
        end else if (rec_wr) begin
            alarm[s_ch] <= (avg > alarm_thr);
        end
    end
`else
    logic unused_alarm_thr;
    assign unused_alarm_thr = ^alarm_thr;
    assign alarm            = '0;
`endif

endmodule

// File: tb/tb_energy_sample_logger.sv
// Scoreboard bench for energy_sample_logger: a queue-based reference model
// predicts popped records and status flags; a negedge monitor compares them.
module tb_energy_sample_logger;
    import energy_logger_pkg::*;

    localparam int DW    = 8;
    localparam int NCH   = 4;
    localparam int AL    = 2;
    localparam int DEPTH = 8;
    localparam int CW    = 2;
    localparam int WIN   = 1 << AL;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           ena = 1'b0;
    logic           s_valid = 1'b0;
    logic [CW-1:0]  s_ch = '0;
    logic [DW-1:0]  s_data = '0;
    logic           rd_en = 1'b0;
    logic           clr_ovf = 1'b0;
    logic [DW-1:0]  alarm_thr = 8'd50;
    logic           r_valid;
    logic [DW-1:0]  r_data;
    logic [CW-1:0]  r_ch;
    logic           empty;
    logic           full;
    logic           overflow;
    logic [NCH-1:0] alarm;

    energy_sample_logger dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .s_valid   (s_valid),
        .s_ch      (s_ch),
        .s_data    (s_data),
        .rd_en     (rd_en),
        .clr_ovf   (clr_ovf),
        .alarm_thr (alarm_thr),
        .r_valid   (r_valid),
        .r_data    (r_data),
        .r_ch      (r_ch),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .alarm     (alarm)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state
    log_rec_t       mq[$];
    log_rec_t       exp_q[$];
    int             msum [NCH];
    int             mcnt [NCH];
    bit             movf = 0;
    bit [NCH-1:0]   malarm = '0;
    bit             exp_rvalid = 0;
    bit             chk_en = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        exp_q.delete();
        for (int i = 0; i < NCH; i++) begin
            msum[i] = 0;
            mcnt[i] = 0;
        end
        movf       = 0;
        malarm     = '0;
        exp_rvalid = 0;
    endtask

    // Drive one cycle of inputs, then advance the model past the edge
    task automatic step(input bit v, input int ch, input int d, input bit rd,
                        input bit en = 1'b1, input bit clr = 1'b0);
        bit       pop;
        bit       drop;
        int       avg;
        log_rec_t rec;
        s_valid = v;
        s_ch    = CW'(ch);
        s_data  = DW'(d);
        rd_en   = rd;
        ena     = en;
        clr_ovf = clr;
        @(posedge clk);
        #1;
        pop  = rd && (mq.size() > 0);
        drop = 0;
        exp_rvalid = pop;
        if (pop) exp_q.push_back(mq.pop_front());
        if (en && v) begin
            msum[ch] += d;
            mcnt[ch]++;
            if (mcnt[ch] == WIN) begin
                avg      = msum[ch] / WIN;
                rec.ch   = CW'(ch);
                rec.data = DW'(avg);
                if (mq.size() < DEPTH) mq.push_back(rec);
                else drop = 1;
`ifdef LOGGER_ALARM_EN
                malarm[ch] = (avg > int'(alarm_thr));
`endif
                msum[ch] = 0;
                mcnt[ch] = 0;
            end
        end
        if (drop) movf = 1;
        else if (clr) movf = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    task automatic do_reset();
        chk_en  = 0;
        rst_n   = 1'b0;
        s_valid = 1'b0;
        rd_en   = 1'b0;
        ena     = 1'b0;
        clr_ovf = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_overflow", overflow, 0);
        check("rst_r_valid", r_valid, 0);
        check("rst_r_data", r_data, 0);
        check("rst_r_ch", r_ch, 0);
        check("rst_alarm", alarm, 0);
        chk_en = 1;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a record
    always @(negedge clk) begin
        if (chk_en) begin
            log_rec_t e;
            check("r_valid", r_valid, exp_rvalid);
            if (r_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_record", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("r_data", r_data, e.data);
                    check("r_ch", r_ch, e.ch);
                end
            end
            check("empty", empty, (mq.size() == 0));
            check("full", full, (mq.size() == DEPTH));
            check("overflow", overflow, movf);
            check("alarm", alarm, malarm);
        end
    end

    initial begin
        model_clear();
        do_reset();

        // Single window on channel 1: (10+20+30+41)/4 = 25
        step(1, 1, 10, 0);
        step(1, 1, 20, 0);
        step(1, 1, 30, 0);
        step(1, 1, 41, 0);
        step(0, 0, 0, 1);
        @(negedge clk); #1;
        check("dir_r_valid", r_valid, 1);
        check("dir_r_ch", r_ch, 1);
        check("dir_r_data", r_data, 25);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);     // pop while empty is ignored
        idle(2);

        // Interleaved ch0/ch3 with a partial ch2 window and ena-low cycles
        step(1, 2, 7, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 100, 0);
            step(1, 3, 255, 0, 1'b0);   // ignored: ena low
            step(1, 3, 255, 0);
        end
        step(1, 2, 9, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(1, 2, 11, 0);
        step(1, 2, 13, 1);          // completes ch2: (7+9+11+13)/4 = 10
        step(0, 0, 0, 1);
        idle(2);

        // Fill, drop, clear, then full write with same-edge pop
        for (int r = 0; r < DEPTH; r++)
            for (int k = 0; k < WIN; k++) step(1, r % NCH, $urandom_range(0, 255), 0);
        for (int k = 0; k < WIN; k++) step(1, 1, 200, 0);
        @(negedge clk); #1;
        check("dir_overflow_set", overflow, 1);
        step(0, 0, 0, 0, 1'b1, 1'b1);
        for (int k = 0; k < WIN - 1; k++) step(1, 2, 77, 0);
        step(1, 2, 77, 1);
        @(negedge clk); #1;
        check("dir_full_held", full, 1);
        check("dir_overflow_clr", overflow, 0);
        for (int k = 0; k < DEPTH + 1; k++) step(0, 0, 0, 1);
        idle(1);

        // Reset mid-window discards the partial ch0 accumulation
        step(1, 0, 250, 0);
        step(1, 0, 250, 0);
        do_reset();
        step(1, 0, 4, 0);
        step(1, 0, 8, 0);
        step(1, 0, 12, 0);
        step(1, 0, 16, 0);
        step(0, 0, 0, 1);
        @(negedge clk); #1;
        check("rst_win_data", r_data, 10);
        step(0, 0, 0, 1);
        idle(1);

`ifdef LOGGER_ALARM_EN
        alarm_thr = 8'd50;
        for (int k = 0; k < WIN; k++) step(1, 2, 60, 0);
        @(negedge clk); #1;
        check("alarm_set", alarm[2], 1);
        for (int k = 0; k < WIN; k++) step(1, 2, 40, 1);
        @(negedge clk); #1;
        check("alarm_clr", alarm[2], 0);
        for (int k = 0; k < 4; k++) step(0, 0, 0, 1);
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0) alarm_thr = DW'($urandom_range(0, 255));
            step($urandom_range(0, 99) < 80, $urandom_range(0, NCH - 1),
                 $urandom_range(0, 255), $urandom_range(0, 99) < 22,
                 $urandom_range(0, 99) < 90, $urandom_range(0, 99) < 3);
        end

        // Drain, bounded
        for (int i = 0; i < DEPTH + 4; i++) step(0, 0, 0, 1);
        idle(1);
        check("drain_scoreboard", exp_q.size(), 0);
        check("drain_model", mq.size(), 0);
        chk_en = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
